// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Write-back arbiter for the general-purpose (GPR) and floating-point (FPR)
// register files. Up to NREQ execution units (0 = ALU, 1 = LSU, 2 = FPU)
// request register writes. Each cycle the block grants at most one GPR write
// and at most one FPR write. Grants are combinational. The write port of each
// file is driven from registers one cycle after the grant.
//
// Build option:
//   WB_FIXED_PRIO_EN  When defined, both arbiters use fixed priority and the
//                     lowest index wins. No pointers are kept, so lower-
//                     priority units may starve.
//                     When undefined (the default), each file has its own
//                     round-robin arbiter with a private pointer.
//
// Ports:
//   clk          input          rising-edge clock
//   rst          input          asynchronous, active-high reset
//   req_valid    input  [N]     per-requester write request
//   req_fpr      input  [N]     target file: 1 = FPR, 0 = GPR
//   req_reg      input  [5N]    destination register, slice i = [5i+4:5i]
//   req_data     input  [32N]   write data, slice i = [32i+31:32i]
//   req_byte     input  [N]     byte write (only bits [7:0] are written)
//   req_ready    output [N]     grant (combinational); forced to 0 during rst
//   gpr_w_en     output         GPR write enable (registered)
//   gpr_w_byte   output         GPR byte mode
//   gpr_wreg     output [5]     GPR write index
//   gpr_wdata    output [32]    GPR write data
//   fpr_w_en     output         FPR write enable (registered)
//   fpr_w_byte   output         FPR byte mode
//   fpr_wreg     output [5]     FPR write index
//   fpr_wdata    output [32]    FPR write data
//
// Notes:
//   The design assumes NREQ >= 2. PTR_W is derived from NREQ and should not
//   be overridden.
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_fpr,
    input  logic [NREQ*5-1:0]    req_reg,
    input  logic [NREQ*32-1:0]   req_data,
    input  logic [NREQ-1:0]      req_byte,
    output logic [NREQ-1:0]      req_ready,
    output logic                 gpr_w_en,
    output logic                 gpr_w_byte,
    output logic [4:0]           gpr_wreg,
    output logic [31:0]          gpr_wdata,
    output logic                 fpr_w_en,
    output logic                 fpr_w_byte,
    output logic [4:0]           fpr_wreg,
    output logic [31:0]          fpr_wdata
);

    // Per-file eligibility: a requester competes only in the file it targets.
    logic [NREQ-1:0] gpr_elig;
    logic [NREQ-1:0] fpr_elig;
    logic [NREQ-1:0] gpr_gnt;
    logic [NREQ-1:0] fpr_gnt;

    assign gpr_elig = req_valid & ~req_fpr;
    assign fpr_elig = req_valid &  req_fpr;

`ifdef WB_FIXED_PRIO_EN

    // The lowest eligible index wins, regardless of history.
    function automatic logic [NREQ-1:0] fixed_grant(input logic [NREQ-1:0] elig);
        logic [NREQ-1:0] g;
        g = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (elig[i] && (g == '0)) begin
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    assign gpr_gnt = fixed_grant(gpr_elig);
    assign fpr_gnt = fixed_grant(fpr_elig);

`else

    logic [PTR_W-1:0] gpr_ptr;
    logic [PTR_W-1:0] fpr_ptr;

    // Round-robin search starting at ptr. Each candidate i is ranked by its
    // distance from the pointer, (i - ptr) mod NREQ, and the eligible
    // candidate with the smallest distance wins. This gives the same result as
    // walking ptr, ptr+1, ... with wrap-around, but indexes vectors only with
    // the loop constant.
    function automatic logic [NREQ-1:0] rr_grant(input logic [NREQ-1:0]  elig,
                                                 input logic [PTR_W-1:0] ptr);
        logic [NREQ-1:0] g;
        int              best_d;
        int              d;
        g      = '0;
        best_d = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + NREQ - int'(ptr)) % NREQ;
            if (elig[i] && (d < best_d)) begin
                best_d = d;
                g      = '0;
                g[i]   = 1'b1;
            end
        end
        return g;
    endfunction

    // The pointer moves to the slot just after the winner, wrapping at NREQ.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [NREQ-1:0] gnt);
        logic [PTR_W-1:0] p;
        p = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                p = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
        return p;
    endfunction

    assign gpr_gnt = rr_grant(gpr_elig, gpr_ptr);
    assign fpr_gnt = rr_grant(fpr_elig, fpr_ptr);

    // The pointers advance only on a grant and otherwise hold their value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpr_ptr <= '0;
            fpr_ptr <= '0;
        end else begin
            if (|gpr_gnt) begin
                gpr_ptr <= next_ptr(gpr_gnt);
            end
            if (|fpr_gnt) begin
                fpr_ptr <= next_ptr(fpr_gnt);
            end
        end
    end

`endif

    // A requester targets one file only, so the two grant vectors are
    // disjoint. OR-ing them gives a single ready per requester.
    assign req_ready = (gpr_gnt | fpr_gnt) & {NREQ{~rst}};

    // -------------------------------------------------------------------------
    // p0: select the granted slice for each file (one-hot mux)
    // -------------------------------------------------------------------------
    logic [4:0]  gpr_reg_p0;
    logic [31:0] gpr_data_p0;
    logic        gpr_byte_p0;
    logic        gpr_vld_p0;
    logic [4:0]  fpr_reg_p0;
    logic [31:0] fpr_data_p0;
    logic        fpr_byte_p0;
    logic        fpr_vld_p0;

    always_comb begin
        gpr_reg_p0  = '0;
        gpr_data_p0 = '0;
        gpr_byte_p0 = 1'b0;
        fpr_reg_p0  = '0;
        fpr_data_p0 = '0;
        fpr_byte_p0 = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gpr_gnt[i]) begin
                gpr_reg_p0  = req_reg[5*i +: 5];
                gpr_data_p0 = req_data[32*i +: 32];
                gpr_byte_p0 = req_byte[i];
            end
            if (fpr_gnt[i]) begin
                fpr_reg_p0  = req_reg[5*i +: 5];
                fpr_data_p0 = req_data[32*i +: 32];
                fpr_byte_p0 = req_byte[i];
            end
        end
    end

    // GPR r0 is hard-wired to zero. The request is still granted and consumed,
    // but it never reaches the write port.
    assign gpr_vld_p0 = (|gpr_gnt) && (gpr_reg_p0 != 5'd0);
    assign fpr_vld_p0 = |fpr_gnt;

    // -------------------------------------------------------------------------
    // p1: registered write ports
    //     Index, data and byte mode are loaded on any grant and otherwise hold
    //     their last value. Only the enable drops on idle cycles.
    // -------------------------------------------------------------------------
    logic        gpr_vld_p1;
    logic        gpr_byte_p1;
    logic [4:0]  gpr_reg_p1;
    logic [31:0] gpr_data_p1;
    logic        fpr_vld_p1;
    logic        fpr_byte_p1;
    logic [4:0]  fpr_reg_p1;
    logic [31:0] fpr_data_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpr_vld_p1  <= 1'b0;
            gpr_byte_p1 <= 1'b0;
            gpr_reg_p1  <= '0;
            gpr_data_p1 <= '0;
            fpr_vld_p1  <= 1'b0;
            fpr_byte_p1 <= 1'b0;
            fpr_reg_p1  <= '0;
            fpr_data_p1 <= '0;
        end else begin
            gpr_vld_p1 <= gpr_vld_p0;
            fpr_vld_p1 <= fpr_vld_p0;
            if (|gpr_gnt) begin
                gpr_byte_p1 <= gpr_byte_p0;
                gpr_reg_p1  <= gpr_reg_p0;
                gpr_data_p1 <= gpr_data_p0;
            end
            if (|fpr_gnt) begin
                fpr_byte_p1 <= fpr_byte_p0;
                fpr_reg_p1  <= fpr_reg_p0;
                fpr_data_p1 <= fpr_data_p0;
            end
        end
    end

    assign gpr_w_en   = gpr_vld_p1;
    assign gpr_w_byte = gpr_byte_p1;
    assign gpr_wreg   = gpr_reg_p1;
    assign gpr_wdata  = gpr_data_p1;
    assign fpr_w_en   = fpr_vld_p1;
    assign fpr_w_byte = fpr_byte_p1;
    assign fpr_wreg   = fpr_reg_p1;
    assign fpr_wdata  = fpr_data_p1;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Scoreboard bench for wb_arbiter. The stimulus process drives requests on the
// falling edge. Shortly afterwards, a reference model picks the expected
// winners from the arbitration rules, checks req_ready, and queues the
// write-port transaction expected on the next cycle. A separate monitor
// samples the write ports just after each rising edge and pops the queues.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int NREQ = 3;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_fpr;
    logic [NREQ*5-1:0]    req_reg;
    logic [NREQ*32-1:0]   req_data;
    logic [NREQ-1:0]      req_byte;
    logic [NREQ-1:0]      req_ready;
    logic                 gpr_w_en;
    logic                 gpr_w_byte;
    logic [4:0]           gpr_wreg;
    logic [31:0]          gpr_wdata;
    logic                 fpr_w_en;
    logic                 fpr_w_byte;
    logic [4:0]           fpr_wreg;
    logic [31:0]          fpr_wdata;

    wb_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_fpr    (req_fpr),
        .req_reg    (req_reg),
        .req_data   (req_data),
        .req_byte   (req_byte),
        .req_ready  (req_ready),
        .gpr_w_en   (gpr_w_en),
        .gpr_w_byte (gpr_w_byte),
        .gpr_wreg   (gpr_wreg),
        .gpr_wdata  (gpr_wdata),
        .fpr_w_en   (fpr_w_en),
        .fpr_w_byte (fpr_w_byte),
        .fpr_wreg   (fpr_wreg),
        .fpr_wdata  (fpr_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          stamp;
        logic [4:0]  r;
        logic [31:0] d;
        logic        b;
    } exp_t;

    exp_t gq[$];
    exp_t fq[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int              m_gptr = 0;
    int              m_fptr = 0;
    int              gsel;
    int              fsel;
    logic [NREQ-1:0] g_last;

    // Walk the requesters in search order from the start point and return the
    // first one that is eligible. Return -1 if none is eligible.
    function automatic int pick(input logic [NREQ-1:0] elig, input int ptr);
        int start;
`ifdef WB_FIXED_PRIO_EN
        start = 0;
`else
        start = ptr;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (elig[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic f, input logic [4:0] r,
                           input logic [31:0] d, input logic b);
        req_valid[i]        = v;
        req_fpr[i]          = f;
        req_reg[5*i +: 5]   = r;
        req_data[32*i +: 32] = d;
        req_byte[i]         = b;
    endtask

    // Called just after a falling edge, once the inputs are set.
    task automatic eval();
        logic [NREQ-1:0] exp_rdy;
        exp_t e;
        #1;
        exp_rdy = '0;
        gsel = pick(req_valid & ~req_fpr, m_gptr);
        fsel = pick(req_valid &  req_fpr, m_fptr);
        if (gsel >= 0) exp_rdy[gsel] = 1'b1;
        if (fsel >= 0) exp_rdy[fsel] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (gsel >= 0) begin
            e.stamp = cyc + 1;
            e.r = req_reg[5*gsel +: 5];
            e.d = req_data[32*gsel +: 32];
            e.b = req_byte[gsel];
            if (e.r != 5'd0) gq.push_back(e);
            m_gptr = (gsel + 1) % NREQ;
        end
        if (fsel >= 0) begin
            e.stamp = cyc + 1;
            e.r = req_reg[5*fsel +: 5];
            e.d = req_data[32*fsel +: 32];
            e.b = req_byte[fsel];
            fq.push_back(e);
            m_fptr = (fsel + 1) % NREQ;
        end
        g_last = exp_rdy;
    endtask

    // Move to the next falling edge and retire the transferred requests.
    task automatic advance();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (g_last[i]) req_valid[i] = 1'b0;
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_gpr_w_en"},   64'(gpr_w_en),   64'd0);
        chk({tag, "_gpr_w_byte"}, 64'(gpr_w_byte), 64'd0);
        chk({tag, "_gpr_wreg"},   64'(gpr_wreg),   64'd0);
        chk({tag, "_gpr_wdata"},  64'(gpr_wdata),  64'd0);
        chk({tag, "_fpr_w_en"},   64'(fpr_w_en),   64'd0);
        chk({tag, "_fpr_w_byte"}, 64'(fpr_w_byte), 64'd0);
        chk({tag, "_fpr_wreg"},   64'(fpr_wreg),   64'd0);
        chk({tag, "_fpr_wdata"},  64'(fpr_wdata),  64'd0);
    endtask

    // ---------------- monitor ----------------
    task automatic check_file(input bit f, input logic en, input logic [4:0] r,
                              input logic [31:0] d, input logic b);
        exp_t  e;
        int    n;
        string p;
        p = f ? "fpr" : "gpr";
        n = f ? fq.size() : gq.size();
        while (n > 0) begin
            e = f ? fq[0] : gq[0];
            if (e.stamp >= cyc) break;
            chk({p, "_missing_write_cycle"}, 64'(cyc), 64'(e.stamp));
            if (f) void'(fq.pop_front()); else void'(gq.pop_front());
            n--;
        end
        if (en) begin
            if (n == 0) begin
                chk({p, "_unexpected_w_en"}, 64'(en), 64'd0);
            end else begin
                e = f ? fq.pop_front() : gq.pop_front();
                chk({p, "_write_cycle"}, 64'(cyc), 64'(e.stamp));
                chk({p, "_wreg"},   64'(r), 64'(e.r));
                chk({p, "_wdata"},  64'(d), 64'(e.d));
                chk({p, "_w_byte"}, 64'(b), 64'(e.b));
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("rst_gpr_w_en", 64'(gpr_w_en), 64'd0);
            chk("rst_fpr_w_en", 64'(fpr_w_en), 64'd0);
        end else begin
            check_file(1'b0, gpr_w_en, gpr_wreg, gpr_wdata, gpr_w_byte);
            check_file(1'b1, fpr_w_en, fpr_wreg, fpr_wdata, fpr_w_byte);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int exp_seq[4];

    initial begin
        rst = 1'b1;
        req_valid = '0; req_fpr = '0; req_reg = '0; req_data = '0; req_byte = '0;
        g_last = '0;

        // Reset: every requester is valid, but nothing may be granted or written.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 5'(i + 1), $urandom, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk_outputs_zero("rst");
        @(negedge clk);
        rst = 1'b0;

        // Contention: all three requesters target the GPR file and stay valid.
`ifdef WB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 2, 0};
`endif
        for (int k = 0; k < 4; k++) begin
            eval();
            chk("contention_order", 64'(gsel), 64'(exp_seq[k]));
            advance();
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i]) set_req(i, 1'b1, 1'b0, 5'(i + 1 + 4*k), $urandom, 1'b0);
        end
        req_valid = '0;
        eval(); advance();

        // Single GPR write from requester 1.
        set_req(1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0);
        eval();
        chk("single_ready1", 64'(req_ready[1]), 64'd1);
        advance();

        // Dual file: requester 0 writes GPR r3, requester 2 writes FPR f7.
        set_req(0, 1'b1, 1'b0, 5'd3, 32'h0BADF00D, 1'b0);
        set_req(2, 1'b1, 1'b1, 5'd7, 32'hCAFE1234, 1'b0);
        eval(); advance();

        // GPR r0 (grant, no write) and FPR f0 in byte mode.
        set_req(0, 1'b1, 1'b0, 5'd0, 32'h00001234, 1'b0);
        set_req(2, 1'b1, 1'b1, 5'd0, 32'h000000AB, 1'b1);
        eval();
        chk("r0_ready0", 64'(req_ready[0]), 64'd1);
        advance();
        eval(); advance();

        // Async reset between a grant and the next clock edge.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 5'(10 + i), $urandom, 1'b0);
        eval();
        #2;
        rst = 1'b1;
        gq.delete(); fq.delete();
        m_gptr = 0; m_fptr = 0;
        #1;
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        #1;
        chk_outputs_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        req_valid = '1;
        eval();
        chk("ptr_after_reset", 64'(gsel), 64'd0);
        advance();

        // Randomized traffic: requesters hold until granted, then may re-issue.
        repeat (1500) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 9) < 6))
                    set_req(i, 1'b1, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                            $urandom, 1'($urandom_range(0, 1)));
            end
            eval(); advance();
        end

        req_valid = '0;
        repeat (3) begin eval(); advance(); end
        @(negedge clk);
        chk("gpr_queue_drained", 64'(gq.size()), 64'd0);
        chk("fpr_queue_drained", 64'(fq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
